range_frame_sequencer: RTL

Upstream feeder for the range finder. Buffers one frame of input samples, then replays it as a go/finish-framed burst on the range finder's `data_in`/`go`/`finish` inputs. The burst meets that block's protocol: `go` only with the first sample, `finish` only with the last, and an idle cycle before the next `go`. Oversized frames are dropped and flagged, so the range finder never sees a malformed frame.

---
 rtl/range_frame_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/range_frame_sequencer.sv
// range_frame_sequencer: buffers one input frame and replays it
// as a go/finish framed burst with a trailing idle cycle.
module range_frame_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             go,
    output logic             finish,
    output logic             frame_done,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        GAP,
        DISCARD
    } state_t;

    state_t state;
    state_t state_n;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    rd;
    logic [CW-1:0]    n;
    logic             rep;

    logic xfer;
    logic full;
    logic last_beat;

    assign in_ready = (state == FILL) || (state == DISCARD);
    assign xfer     = in_valid && in_ready;
    assign full     = (count == CW'(DEPTH));

    // a 1-sample frame is shown twice so go and finish never coincide
    assign last_beat = (n == CW'(1)) ? rep : (rd == n - CW'(1));

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_n;
        end
    end

    // next state and burst outputs
    always_comb begin
        state_n    = state;
        out_data   = '0;
        go         = 1'b0;
        finish     = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            FILL: begin
                if (xfer && in_last) begin
                    state_n = full ? FILL : DRAIN;
                end else if (xfer && full) begin
                    state_n = DISCARD;
                end
            end
            DRAIN: begin
                out_data = mem[rd[AW-1:0]];
                go       = (rd == '0) && !rep;
                finish   = last_beat;
                if (last_beat) begin
                    state_n = GAP;
                end
            end
            GAP: begin
                frame_done = 1'b1;
                state_n    = FILL;
            end
            DISCARD: begin
                if (xfer && in_last) begin
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    // indices, frame length and sticky overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            rd       <= '0;
            n        <= '0;
            rep      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (xfer) begin
                        if (full) begin
                            overflow <= 1'b1;
                            if (in_last) begin
                                count <= '0;
                            end
                        end else begin
                            count <= count + CW'(1);
                            if (in_last) begin
                                n <= count + CW'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (n == CW'(1)) begin
                        rep <= 1'b1;
                    end else begin
                        rd <= rd + CW'(1);
                    end
                end
                GAP: begin
                    count <= '0;
                    rd    <= '0;
                    rep   <= 1'b0;
                end
                DISCARD: begin
                    if (xfer && in_last) begin
                        count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // sample buffer; only written while filling a frame that still fits
    always_ff @(posedge clock) begin
        if (!reset && state == FILL && xfer && !full) begin
            mem[count[AW-1:0]] <= in_data;
        end
    end

endmodule
